alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL take parameter N_SLOTS, default 10, the number of operation slots, each slot holding 3 registers (A, B, R).
REQ-002 The block SHALL take parameter ADDR_W, default 5, the register-file address width, with 3*N_SLOTS <= 2**ADDR_W.
REQ-003 The block SHALL take parameter OP_W, default 2, the ALU-op width; the button count is 2**OP_W.
REQ-004 The block SHALL take parameter SHOW_CYC, default 3, the display dwell in clocks for operand and result views.
REQ-005 The block SHALL take parameter REPLAY_CYC, default 20000000, the dwell in clocks per replayed address.
REQ-006 The block SHALL have the ports: clk in 1 system clock; rst in 1 reset; op_btn in 2**OP_W one-hot op request; mode_btn in 1 replay toggle; lfsr_we out 1 LFSR advance; rf_we out 1 register-file write enable; wr_sel out 1 write source (0 LFSR, 1 ALU); rd_addr, rs1_addr, rs2_addr out ADDR_W each; alu_op out OP_W; disp_en out 1 display enable; leds out 2**OP_W+2 status; valid_slots out $clog2(N_SLOTS+1) completed slot count.
REQ-007 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-008 The block SHALL implement states GEN_A, GEN_B, SHOW_A, SHOW_B, WAIT_OP, EXEC, SHOW_R, REPLAY, REPLAY_HOLD.
REQ-009 The block SHALL keep slot base pointer base, incremented by 3 without multiplication; slot addresses are A=base, B=base+1, R=base+2.
REQ-010 GEN_A SHALL last one cycle with lfsr_we=1, rf_we=1, wr_sel=0, rd_addr=base, then go to GEN_B.
REQ-011 GEN_B SHALL last one cycle with lfsr_we=1, rf_we=1, wr_sel=0, rd_addr=base+1, then go to SHOW_A.
REQ-012 SHOW_A and SHOW_B SHALL each last exactly SHOW_CYC cycles with disp_en=1, rs2_addr=A and B respectively, and leds[0] and leds[1] respectively set.
REQ-013 WAIT_OP SHALL hold disp_en=0 until op_btn is non-zero; entry SHALL be refused (the block stays in WAIT_OP) while op_btn was non-zero in the previous cycle, so the button must be released between operations.
REQ-014 EXEC SHALL last one cycle with rf_we=1, wr_sel=1, rs1_addr=A, rs2_addr=B, rd_addr=R, alu_op = index of the lowest set op_btn bit latched on WAIT_OP exit, and leds[2+alu_op]=1.
REQ-015 SHOW_R SHALL last SHOW_CYC cycles with disp_en=1 and rs2_addr=R; on exit base SHALL advance by 3, wrapping to 0 after slot N_SLOTS-1, then go to GEN_A.
REQ-016 valid_slots SHALL increment on each SHOW_R exit and saturate at N_SLOTS.
REQ-017 A mode_btn rising edge in any non-replay state SHALL go to REPLAY at the next clock and abort the current slot without advancing base or valid_slots.
REQ-018 If valid_slots=0, a mode_btn rising edge SHALL be ignored.
REQ-019 REPLAY SHALL start at address 0 and present rs2_addr=address with disp_en=1, entering REPLAY_HOLD for REPLAY_CYC cycles per address.
REQ-020 Replay SHALL step addresses 0 through 3*valid_slots-1, then return to GEN_A at the current base.
REQ-021 A mode_btn rising edge during replay SHALL return to GEN_A immediately.
REQ-022 When N_SLOTS slots are complete, the next slot SHALL overwrite slot 0; valid_slots SHALL stay N_SLOTS.
REQ-023 Every output not driven by the current state SHALL be 0; outputs SHALL be a function of state and registered data only, except alu_op/leds in EXEC.
REQ-024 The dwell counters SHALL clear on every state entry.

Reset
REQ-025 On rst the block SHALL enter GEN_A with base=0, valid_slots=0, all counters 0, and the latched op and mode_btn edge history 0.
REQ-026 During rst all outputs SHALL be 0; lfsr_we and rf_we SHALL be 0 in the cycle after rst deasserts until the state register is in GEN_A.
REQ-027 A rst mid-slot SHALL discard the partial slot.

Structure
REQ-028 A shared package alu_seq_pkg SHALL hold the state enum and the led index constants.
REQ-029 A single sub-module dwell_timer SHALL be parametrised by width and provide load/done for both the SHOW_CYC and REPLAY_CYC dwells.

Verification
REQ-030 Release rst, op_btn=0 -> rd_addr 0 then 1 with rf_we=1 on two cycles; SHOW_A for 3 cycles with rs2_addr=0; SHOW_B for 3 cycles with rs2_addr=1; the block waits in WAIT_OP.
REQ-031 In WAIT_OP, op_btn=4'b0110 -> EXEC alu_op=1, rd_addr=2, rs1=0, rs2=1, leds=6'b001000; the next slot uses base=3.
REQ-032 Hold op_btn across SHOW_R into the next WAIT_OP -> no EXEC until op_btn=0 for at least one cycle.
REQ-033 Complete 11 slots with N_SLOTS=10 -> the 11th writes addresses 0..2 and valid_slots=10.
REQ-034 REPLAY_CYC=2, valid_slots=2, pulse mode_btn -> rs2_addr 0..5 each held 2 cycles, then GEN_A with base unchanged; mode_btn with valid_slots=0 is ignored.
REQ-035 Assert rst during SHOW_R -> outputs 0 immediately, GEN_A with base=0 and valid_slots=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents: controller state enum, status LED bit positions, replay-state helper.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    GEN_A,
    GEN_B,
    SHOW_A,
    SHOW_B,
    WAIT_OP,
    EXEC,
    SHOW_R,
    REPLAY,
    REPLAY_HOLD
  } state_t;

  // Status LED bit positions: operand A view, operand B view, then one LED
  // per ALU op starting at LED_OP0.
  localparam int LED_A   = 0;
  localparam int LED_B   = 1;
  localparam int LED_OP0 = 2;

  function automatic logic is_replay(input state_t s);
    return (s == REPLAY) || (s == REPLAY_HOLD);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts cycles since the last load, done once limit cycles have elapsed.
// Latency: done rises in the limit-th cycle after load (cycle after load counts as 1).
// Backpressure: none; the counter saturates at done until the next load.
//
// Ports: clk, rst (async, active-high); load clears the count; limit is the
// dwell length in cycles (0 behaves like 1); done is combinational from the count.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_p1;

  // Compare one bit wider so a full-scale limit never wraps.
  assign cnt_p1 = {1'b0, cnt} + (W+1)'(1);
  assign done   = (cnt_p1 >= {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer driving an LFSR/register-file/ALU datapath: generate operands, show them, wait for an op, execute, show result, replay.
// Latency: GEN 2 cycles, each view SHOW_CYC cycles, EXEC 1 cycle after a fresh op press; REPLAY_CYC cycles per replayed address.
// Backpressure: none; op presses are accepted only in WAIT_OP and only after the buttons were released for a cycle.
//
// Ports: clk, rst (async, active-high); op_btn one-hot op request; mode_btn replay toggle;
// lfsr_we/rf_we/wr_sel/rd_addr/rs1_addr/rs2_addr/alu_op datapath controls; disp_en display
// enable; leds status (A view, B view, active op); valid_slots number of completed slots.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int N_SLOTS    = 10,
  parameter int ADDR_W     = 5,
  parameter int OP_W       = 2,
  parameter int SHOW_CYC   = 3,
  parameter int REPLAY_CYC = 20000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2**OP_W-1:0]           op_btn,
  input  logic                         mode_btn,
  output logic                         lfsr_we,
  output logic                         rf_we,
  output logic                         wr_sel,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic [ADDR_W-1:0]            rs1_addr,
  output logic [ADDR_W-1:0]            rs2_addr,
  output logic [OP_W-1:0]              alu_op,
  output logic                         disp_en,
  output logic [2**OP_W+1:0]           leds,
  output logic [$clog2(N_SLOTS+1)-1:0] valid_slots
);

  localparam int N_BTN  = 2**OP_W;
  localparam int LEDS_W = N_BTN + 2;
  localparam int VW     = $clog2(N_SLOTS + 1);
  localparam int DW_MAX = (SHOW_CYC > REPLAY_CYC) ? SHOW_CYC : REPLAY_CYC;
  localparam int TW     = $clog2(DW_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(3 * (N_SLOTS - 1));

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rp_addr;
  logic [OP_W-1:0]   op_lat;
  logic [OP_W-1:0]   op_idx;
  logic              op_any, op_prev;
  logic              mode_q, mode_edge;
  logic              run_q;
  logic              tmr_load, tmr_done;
  logic [TW-1:0]     tmr_limit;
  logic              slot_done, rp_step, exec_go, rp_last;
  logic [ADDR_W:0]   vs_ext, rp_span;

  assign op_any    = |op_btn;
  assign mode_edge = mode_btn & ~mode_q;

  // Lowest set button wins when several are pressed together.
  always_comb begin
    op_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (op_btn[i]) op_idx = OP_W'(i);
    end
  end

  // Replay covers 3*valid_slots addresses; shift-add keeps it multiplier-free.
  assign vs_ext  = (ADDR_W+1)'(valid_slots);
  assign rp_span = (vs_ext << 1) + vs_ext;
  assign rp_last = (({1'b0, rp_addr} + (ADDR_W+1)'(1)) == rp_span);

  assign tmr_limit = (state == REPLAY_HOLD) ? TW'(REPLAY_CYC) : TW'(SHOW_CYC);

  dwell_timer #(.W(TW)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GEN_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    slot_done = 1'b0;
    rp_step   = 1'b0;
    exec_go   = 1'b0;
    tmr_load  = 1'b0;
    // run_q holds GEN_A quiet for the first cycle after reset so no write
    // is issued before the controller is actually running.
    if (!run_q) begin
      state_nxt = GEN_A;
    end else if (mode_edge && is_replay(state)) begin
      state_nxt = GEN_A;
    end else if (mode_edge && (valid_slots != '0)) begin
      state_nxt = REPLAY;
    end else begin
      case (state)
        GEN_A:   state_nxt = GEN_B;
        GEN_B:   state_nxt = SHOW_A;
        SHOW_A:  if (tmr_done) state_nxt = SHOW_B;
        SHOW_B:  if (tmr_done) state_nxt = WAIT_OP;
        WAIT_OP: begin
          // Only a fresh press counts: a button still held from the last
          // operation must be released for at least one cycle first.
          if (op_any && !op_prev) begin
            exec_go   = 1'b1;
            state_nxt = EXEC;
          end
        end
        EXEC:    state_nxt = SHOW_R;
        SHOW_R: begin
          if (tmr_done) begin
            slot_done = 1'b1;
            state_nxt = GEN_A;
          end
        end
        REPLAY:  state_nxt = REPLAY_HOLD;
        REPLAY_HOLD: begin
          if (tmr_done) begin
            if (rp_last) state_nxt = GEN_A;
            else         rp_step   = 1'b1;
          end
        end
        default: state_nxt = GEN_A;
      endcase
    end
    // Every state entry, and every new replay address, restarts the dwell.
    tmr_load = (state_nxt != state) || rp_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base        <= '0;
      valid_slots <= '0;
      op_lat      <= '0;
      op_prev     <= 1'b0;
      mode_q      <= 1'b0;
      run_q       <= 1'b0;
      rp_addr     <= '0;
    end else begin
      run_q   <= 1'b1;
      op_prev <= op_any;
      mode_q  <= mode_btn;
      if (exec_go) op_lat <= op_idx;
      if (slot_done) begin
        base <= (base == LAST_BASE) ? '0 : base + ADDR_W'(3);
        if (valid_slots != VW'(N_SLOTS)) valid_slots <= valid_slots + VW'(1);
      end
      if ((state_nxt == REPLAY) && (state != REPLAY)) rp_addr <= '0;
      else if (rp_step)                                rp_addr <= rp_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    lfsr_we  = 1'b0;
    rf_we    = 1'b0;
    wr_sel   = 1'b0;
    rd_addr  = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    alu_op   = '0;
    disp_en  = 1'b0;
    leds     = '0;
    if (run_q) begin
      case (state)
        GEN_A: begin
          lfsr_we = 1'b1;
          rf_we   = 1'b1;
          rd_addr = base;
        end
        GEN_B: begin
          lfsr_we = 1'b1;
          rf_we   = 1'b1;
          rd_addr = base + ADDR_W'(1);
        end
        SHOW_A: begin
          disp_en  = 1'b1;
          rs2_addr = base;
          leds     = LEDS_W'(1) << LED_A;
        end
        SHOW_B: begin
          disp_en  = 1'b1;
          rs2_addr = base + ADDR_W'(1);
          leds     = LEDS_W'(1) << LED_B;
        end
        EXEC: begin
          rf_we    = 1'b1;
          wr_sel   = 1'b1;
          rs1_addr = base;
          rs2_addr = base + ADDR_W'(1);
          rd_addr  = base + ADDR_W'(2);
          alu_op   = op_lat;
          leds     = LEDS_W'(1) << (LED_OP0 + int'(op_lat));
        end
        SHOW_R: begin
          disp_en  = 1'b1;
          rs2_addr = base + ADDR_W'(2);
        end
        REPLAY_HOLD: begin
          disp_en  = 1'b1;
          rs2_addr = rp_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: table of op presses, hand-written corner sequences, randomized slots.
// Latency: expectations are checked once per cycle on the falling clock edge.
// Backpressure: n/a (bench drives buttons directly).
module tb_alu_seq_ctrl;

  localparam int NS = 10;
  localparam int SC = 3;
  localparam int RC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_btn = 4'b0;
  logic       mode_btn = 1'b0;

  logic       lfsr_we, rf_we, wr_sel, disp_en;
  logic [4:0] rd_addr, rs1_addr, rs2_addr;
  logic [1:0] alu_op;
  logic [5:0] leds;
  logic [3:0] valid_slots;

  always #5 clk = ~clk;

  alu_seq_ctrl #(
    .N_SLOTS(NS), .ADDR_W(5), .OP_W(2), .SHOW_CYC(SC), .REPLAY_CYC(RC)
  ) dut (
    .clk(clk), .rst(rst), .op_btn(op_btn), .mode_btn(mode_btn),
    .lfsr_we(lfsr_we), .rf_we(rf_we), .wr_sel(wr_sel),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .alu_op(alu_op), .disp_en(disp_en), .leds(leds), .valid_slots(valid_slots)
  );

  typedef struct packed {
    logic       lfsr_we;
    logic       rf_we;
    logic       wr_sel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] alu_op;
    logic       disp_en;
    logic [5:0] leds;
    logic [3:0] valid;
  } obs_t;

  typedef struct {
    logic [3:0] op;
    logic [1:0] xop;
    logic [5:0] xleds;
    int         wait_n;
  } vec_t;

  obs_t cur;
  assign cur = {lfsr_we, rf_we, wr_sel, rd_addr, rs1_addr, rs2_addr,
                alu_op, disp_en, leds, valid_slots};

  int total = 0;
  int bad   = 0;
  int m_slots = 0;   // slots completed since the last reset

  function automatic int m_base();
    return (m_slots % NS) * 3;
  endfunction

  function automatic logic [3:0] m_valid();
    return (m_slots > NS) ? 4'(NS) : 4'(m_slots);
  endfunction

  // Lowest set bit via v & -v, then its position.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    int x;
    x = int'(v);
    x = x & (-x);
    return 2'($clog2(x));
  endfunction

  function automatic obs_t e_zero();
    obs_t e;
    e = '0;
    e.valid = m_valid();
    return e;
  endfunction

  function automatic obs_t e_gen(input int a);
    obs_t e;
    e = e_zero();
    e.lfsr_we = 1'b1;
    e.rf_we   = 1'b1;
    e.rd      = 5'(a);
    return e;
  endfunction

  function automatic obs_t e_disp(input int a, input int led);
    obs_t e;
    e = e_zero();
    e.disp_en = 1'b1;
    e.rs2     = 5'(a);
    if (led >= 0) e.leds = 6'(1) << led;
    return e;
  endfunction

  function automatic obs_t e_exec(input logic [1:0] op, input logic [5:0] l);
    obs_t e;
    e = e_zero();
    e.rf_we  = 1'b1;
    e.wr_sel = 1'b1;
    e.rs1    = 5'(m_base());
    e.rs2    = 5'(m_base() + 1);
    e.rd     = 5'(m_base() + 2);
    e.alu_op = op;
    e.leds   = l;
    return e;
  endfunction

  task automatic cmp(input string nm, input obs_t e);
    total++;
    if (cur !== e) begin
      bad++;
      $display("FAIL %s t=%0t: got lfsr=%b rf=%b sel=%b rd=%0d rs1=%0d rs2=%0d op=%0d disp=%b leds=%b vs=%0d | want lfsr=%b rf=%b sel=%b rd=%0d rs1=%0d rs2=%0d op=%0d disp=%b leds=%b vs=%0d",
               nm, $time, cur.lfsr_we, cur.rf_we, cur.wr_sel, cur.rd, cur.rs1, cur.rs2,
               cur.alu_op, cur.disp_en, cur.leds, cur.valid,
               e.lfsr_we, e.rf_we, e.wr_sel, e.rd, e.rs1, e.rs2,
               e.alu_op, e.disp_en, e.leds, e.valid);
    end
  endtask

  task automatic step(input string nm, input obs_t e);
    @(negedge clk);
    cmp(nm, e);
  endtask

  // Reset asserted asynchronously between edges; outputs must drop at once.
  task automatic do_reset();
    #2;
    rst      = 1'b1;
    op_btn   = 4'b0;
    mode_btn = 1'b0;
    m_slots  = 0;
    #1;
    cmp("rst_immediate", e_zero());
    @(negedge clk);
    cmp("rst_hold", e_zero());
    rst = 1'b0;
    #1;
    cmp("post_rst_quiet", e_zero());
  endtask

  task automatic gen_steps();
    step("gen_a", e_gen(m_base()));
    step("gen_b", e_gen(m_base() + 1));
  endtask

  task automatic show_steps();
    for (int c = 0; c < SC; c++) step("show_a", e_disp(m_base(), 0));
    for (int c = 0; c < SC; c++) step("show_b", e_disp(m_base() + 1, 1));
  endtask

  // WAIT_OP for wait_n observed cycles; a held button is released one cycle
  // before the press so the press is a fresh one.
  task automatic finish_slot(input logic [3:0] op, input logic [1:0] xop,
                             input logic [5:0] xleds, input int wait_n, input bit hold);
    for (int i = 0; i < wait_n; i++) begin
      step("wait_op", e_zero());
      if (i == wait_n - 1)      op_btn = op;
      else if (i == wait_n - 2) op_btn = 4'b0;
    end
    step("exec", e_exec(xop, xleds));
    if (!hold) op_btn = 4'b0;
    for (int c = 0; c < SC; c++) step("show_r", e_disp(m_base() + 2, -1));
    m_slots++;
  endtask

  task automatic replay_body();
    for (int a = 0; a < 3 * int'(m_valid()); a++)
      for (int c = 0; c < RC; c++) step("replay_addr", e_disp(a, -1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    logic [3:0] rop;
    int         rw;
    bit         rh;

    tbl[0] = '{4'b0110, 2'd1, 6'b001000, 1};
    tbl[1] = '{4'b0001, 2'd0, 6'b000100, 2};
    tbl[2] = '{4'b0100, 2'd2, 6'b010000, 1};
    tbl[3] = '{4'b1000, 2'd3, 6'b100000, 3};
    tbl[4] = '{4'b1111, 2'd0, 6'b000100, 1};
    tbl[5] = '{4'b1100, 2'd2, 6'b010000, 2};
    tbl[6] = '{4'b1010, 2'd1, 6'b001000, 1};
    tbl[7] = '{4'b0011, 2'd0, 6'b000100, 1};

    do_reset();

    // Table-driven slots; the first one also checks that mode is ignored
    // while no slot has completed.
    for (int i = 0; i < 8; i++) begin
      gen_steps();
      show_steps();
      if (i == 0) begin
        step("wait_pre_mode", e_zero());
        mode_btn = 1'b1;
        step("mode_ignored", e_zero());
        mode_btn = 1'b0;
        step("mode_ignored2", e_zero());
      end
      finish_slot(tbl[i].op, tbl[i].xop, tbl[i].xleds, tbl[i].wait_n, 1'b0);
    end

    // Button held from one EXEC into the next WAIT_OP: refused until released.
    gen_steps();
    show_steps();
    finish_slot(4'b0010, 2'd1, 6'b001000, 1, 1'b1);
    gen_steps();
    show_steps();
    finish_slot(4'b1000, 2'd3, 6'b100000, 5, 1'b0);

    // Eleventh slot wraps onto addresses 0..2, valid_slots saturates.
    gen_steps();
    show_steps();
    finish_slot(4'b0001, 2'd0, 6'b000100, 1, 1'b0);
    step("wrap_next_gen", e_gen(m_base()));
    step("wrap_next_gen_b", e_gen(m_base() + 1));

    // Reset in the middle of SHOW_R discards the slot.
    show_steps();
    step("wait_op", e_zero());
    op_btn = 4'b0100;
    step("exec", e_exec(2'd2, 6'b010000));
    op_btn = 4'b0;
    step("show_r", e_disp(m_base() + 2, -1));
    do_reset();

    // Two slots, then replay from WAIT_OP.
    for (int i = 0; i < 2; i++) begin
      rop = 4'($urandom_range(1, 15));
      gen_steps();
      show_steps();
      finish_slot(rop, low_idx(rop), 6'(4) << low_idx(rop), 1, 1'b0);
    end
    gen_steps();
    show_steps();
    step("wait_op", e_zero());
    mode_btn = 1'b1;
    step("replay_entry", e_zero());
    mode_btn = 1'b0;
    replay_body();
    gen_steps();
    show_steps();
    finish_slot(4'b0100, 2'd2, 6'b010000, 1, 1'b0);

    // Abort during SHOW_A, then abort the replay itself.
    gen_steps();
    step("show_a", e_disp(m_base(), 0));
    mode_btn = 1'b1;
    step("replay_entry", e_zero());
    mode_btn = 1'b0;
    step("replay_addr", e_disp(0, -1));
    step("replay_addr", e_disp(0, -1));
    step("replay_addr", e_disp(1, -1));
    mode_btn = 1'b1;
    gen_steps();
    mode_btn = 1'b0;
    show_steps();
    finish_slot(4'b1000, 2'd3, 6'b100000, 1, 1'b0);

    // Randomized slots with occasional replays and held buttons.
    for (int k = 0; k < 20; k++) begin
      rop = 4'($urandom_range(1, 15));
      rw  = int'($urandom_range(2, 4));
      rh  = 1'($urandom_range(0, 1));
      gen_steps();
      show_steps();
      if ((m_valid() != 4'd0) && ($urandom_range(0, 3) == 0)) begin
        step("wait_op", e_zero());
        mode_btn = 1'b1;
        step("replay_entry", e_zero());
        mode_btn = 1'b0;
        replay_body();
        gen_steps();
        show_steps();
      end
      finish_slot(rop, low_idx(rop), 6'(4) << low_idx(rop), rw, rh);
    end
    op_btn = 4'b0;
    step("final_gen", e_gen(m_base()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
